// File: rtl/dmem_arbiter_pkg.sv
// Shared types and sizing for the data-memory arbiter: FSM state, owner tag,
// the lane-vector type and the burst address helper.
package mem_arb_pkg;
  localparam int VEC_SIZE  = 4;
  localparam int REG_SIZE  = 16;
  localparam int DATA_SIZE = 8;
  localparam int MAX_WAIT  = 8;
  localparam int BURST_W   = 8;

  typedef logic [VEC_SIZE-1:0][DATA_SIZE-1:0] lanes_t;

  typedef enum logic [1:0] {ST_IDLE, ST_HOST, ST_DONE} state_e;
  typedef enum logic [1:0] {OWN_NONE, OWN_PIPE, OWN_HOST} owner_e;

  // Beat address wraps modulo 2^REG_SIZE.
  function automatic logic [REG_SIZE-1:0] beat_addr(input logic [REG_SIZE-1:0] base,
                                                   input logic [BURST_W-1:0]  idx);
    return base + REG_SIZE'(32'(idx) * 32'(VEC_SIZE));
  endfunction
endpackage

// File: rtl/dmem_arbiter_if.sv
// Pipeline, host and memory-port signals of the arbiter. The slave modport is
// the arbiter's view; master is the surrounding environment.
interface dmem_arbiter_if;
  import mem_arb_pkg::*;

  logic                pipe_req, pipe_we, pipe_stall, pipe_rvalid;
  logic [REG_SIZE-1:0] pipe_addr;
  lanes_t              pipe_wdata, pipe_rdata;

  logic                host_req, host_we, host_beat, host_rvalid, host_done;
  logic [REG_SIZE-1:0] host_addr;
  logic [BURST_W-1:0]  host_len;
  lanes_t              host_wdata, host_rdata;

  logic                mem_we;
  logic [REG_SIZE-1:0] mem_addr;
  lanes_t              mem_wdata, mem_rdata;

  modport slave (
    input  pipe_req, pipe_we, pipe_addr, pipe_wdata,
    input  host_req, host_we, host_addr, host_len, host_wdata, mem_rdata,
    output pipe_stall, pipe_rvalid, pipe_rdata,
    output host_beat, host_rvalid, host_rdata, host_done,
    output mem_we, mem_addr, mem_wdata
  );

  modport master (
    output pipe_req, pipe_we, pipe_addr, pipe_wdata,
    output host_req, host_we, host_addr, host_len, host_wdata, mem_rdata,
    input  pipe_stall, pipe_rvalid, pipe_rdata,
    input  host_beat, host_rvalid, host_rdata, host_done,
    input  mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/dmem_arbiter_read_return.sv
// Remembers who owned the port last cycle and whether it read, then steers
// mem_rdata back to that requester.
module arb_read_return
  import mem_arb_pkg::*;
(
  input  logic   clk,
  input  logic   reset,
  input  owner_e owner_i,
  input  logic   rd_i,
  input  lanes_t mem_rdata_i,
  output logic   pipe_rvalid_o,
  output lanes_t pipe_rdata_o,
  output logic   host_rvalid_o,
  output lanes_t host_rdata_o
);
  owner_e tag_q;
  logic   rd_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      tag_q <= OWN_NONE;
      rd_q  <= 1'b0;
    end else begin
      tag_q <= owner_i;
      rd_q  <= rd_i;
    end
  end

  // Gated by reset so a read issued just before reset never returns.
  assign pipe_rvalid_o = !reset && rd_q && (tag_q == OWN_PIPE);
  assign host_rvalid_o = !reset && rd_q && (tag_q == OWN_HOST);
  assign pipe_rdata_o  = pipe_rvalid_o ? mem_rdata_i : '0;
  assign host_rdata_o  = host_rvalid_o ? mem_rdata_i : '0;
endmodule

// File: rtl/dmem_arbiter.sv
// Single-port data-memory arbiter: zero-latency pipeline pass-through, host
// bursts with a starvation-bounding wait counter, one-cycle read return.
module dmem_arbiter
  import mem_arb_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  dmem_arbiter_if.slave bus
);
  localparam int WAIT_W = $clog2(MAX_WAIT + 1);

  state_e              state_q, state_d;
  logic [WAIT_W-1:0]   wait_q, wait_d;
  logic [BURST_W-1:0]  beat_q, beat_d, len_q, len_d;
  logic [REG_SIZE-1:0] base_q, base_d, addr_q, addr_d;
  logic                we_q, we_d;

  logic                force_grant, pipe_grant, host_start, host_act, last_beat;
  logic                mem_we_c, rd_c;
  logic [REG_SIZE-1:0] mem_addr_c;
  lanes_t              mem_wdata_c;
  owner_e              owner_c;

  assign force_grant = bus.host_req && (wait_q == WAIT_W'(MAX_WAIT));
  assign pipe_grant  = !reset && bus.pipe_req &&
                       ((state_q == ST_IDLE && !force_grant) || state_q == ST_DONE);
  assign host_start  = !reset && state_q == ST_IDLE && bus.host_req &&
                       (!bus.pipe_req || force_grant);
  assign host_act    = !reset && state_q == ST_HOST;
  assign last_beat   = beat_q == len_q - BURST_W'(1);

  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    base_d  = base_q;
    len_d   = len_q;
    we_d    = we_q;
    case (state_q)
      ST_IDLE: if (host_start) begin
        base_d  = bus.host_addr;
        len_d   = bus.host_len;
        we_d    = bus.host_we;
        beat_d  = '0;
        state_d = (bus.host_len == '0) ? ST_DONE : ST_HOST;
      end
      ST_HOST: begin
        beat_d = beat_q + BURST_W'(1);
        if (last_beat) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // Counts only while the host is actually waiting; a running burst ignores host_req.
    if (bus.host_req && !host_start && state_q != ST_HOST)
      wait_d = (wait_q == WAIT_W'(MAX_WAIT)) ? wait_q : wait_q + WAIT_W'(1);
    else
      wait_d = '0;
  end

  always_comb begin
    mem_we_c    = 1'b0;
    mem_addr_c  = reset ? '0 : addr_q;
    mem_wdata_c = '0;
    owner_c     = OWN_NONE;
    rd_c        = 1'b0;
    if (pipe_grant) begin
      mem_we_c    = bus.pipe_we;
      mem_addr_c  = bus.pipe_addr;
      mem_wdata_c = bus.pipe_we ? bus.pipe_wdata : '0;
      owner_c     = OWN_PIPE;
      rd_c        = !bus.pipe_we;
    end else if (host_act) begin
      mem_we_c    = we_q;
      mem_addr_c  = beat_addr(base_q, beat_q);
      mem_wdata_c = we_q ? bus.host_wdata : '0;
      owner_c     = OWN_HOST;
      rd_c        = !we_q;
    end
    addr_d = mem_addr_c;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      wait_q  <= '0;
      beat_q  <= '0;
      len_q   <= '0;
      base_q  <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      beat_q  <= beat_d;
      len_q   <= len_d;
      base_q  <= base_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
    end
  end

  assign bus.mem_we     = mem_we_c;
  assign bus.mem_addr   = mem_addr_c;
  assign bus.mem_wdata  = mem_wdata_c;
  assign bus.pipe_stall = !reset && bus.pipe_req && !pipe_grant;
  assign bus.host_beat  = host_act;
  assign bus.host_done  = !reset && state_q == ST_DONE;

  arb_read_return u_rr (
    .clk          (clk),
    .reset        (reset),
    .owner_i      (owner_c),
    .rd_i         (rd_c),
    .mem_rdata_i  (bus.mem_rdata),
    .pipe_rvalid_o(bus.pipe_rvalid),
    .pipe_rdata_o (bus.pipe_rdata),
    .host_rvalid_o(bus.host_rvalid),
    .host_rdata_o (bus.host_rdata)
  );
endmodule
